// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// stage bit masks and the hazard FSM state encoding.
package pipe_ctrl_pkg;

  // Stage indices into the 6-bit stage_en / stage_vld vectors.
  localparam int unsigned ST_F       = 0;
  localparam int unsigned ST_D       = 1;
  localparam int unsigned ST_RR      = 2;
  localparam int unsigned ST_EX      = 3;
  localparam int unsigned ST_MA      = 4;
  localparam int unsigned ST_WB      = 5;
  localparam int unsigned NUM_STAGES = 6;

  // Hazard FSM states.
  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_LDSTALL = 2'd1,
    S_MCSTALL = 2'd2,
    S_FLUSH   = 2'd3
  } hz_state_t;

  // One-hot mask selecting a single stage.
  function automatic logic [NUM_STAGES-1:0] stg_bit(input int unsigned idx);
    stg_bit = {{(NUM_STAGES-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// fwd_sel: priority forwarding mux for one EX operand. The lowest-index
// (youngest) slot whose destination matches the source register wins;
// with no match, or with the source unused, the register-file data passes.
module fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int N_FWD  = 2
) (
  input  logic [REG_AW-1:0]       src,
  input  logic                    src_use,
  input  logic [DATA_W-1:0]       rf_data,
  input  logic [N_FWD-1:0]        slot_vld,
  input  logic [N_FWD*REG_AW-1:0] slot_rd,
  input  logic [N_FWD*DATA_W-1:0] slot_data,
  output logic [DATA_W-1:0]       data
);

  logic [N_FWD-1:0] hit;

  // Per-slot match: slot holds a valid producer of the used source register.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_FWD; i++) begin
      hit[i] = src_use & slot_vld[i] & (slot_rd[i*REG_AW +: REG_AW] == src);
    end
  end

  // Walk from oldest to youngest so the youngest matching slot overrides.
  always_comb begin
    data = rf_data;
    for (int i = N_FWD - 1; i >= 0; i--) begin
      data = hit[i] ? slot_data[i*DATA_W +: DATA_W] : data;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: six-stage pipeline hazard controller. Resolves
// mispredict flushes, multi-cycle EX stalls, load-use stalls and decode
// jumps (in that priority), drives per-stage enable/valid and the fetch PC,
// and forwards EX operands from the producer slots.
// Optional build macro HAZ_STATS_EN adds saturating stall/flush cycle
// counters on ports stall_cycles and flush_cycles.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int REG_AW    = 3,
  parameter int N_FWD     = 2,
  parameter int FLUSH_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       pc_next,
  input  logic                    jmp_req,
  input  logic [DATA_W-1:0]       jmp_tgt,
  input  logic                    mispredict,
  input  logic [DATA_W-1:0]       br_tgt,
  input  logic                    mc_busy,
  input  logic [REG_AW-1:0]       rr_ra,
  input  logic [REG_AW-1:0]       rr_rb,
  input  logic                    rr_ra_use,
  input  logic                    rr_rb_use,
  input  logic [DATA_W-1:0]       rr_data_a,
  input  logic [DATA_W-1:0]       rr_data_b,
  input  logic [N_FWD-1:0]        fwd_vld,
  input  logic [N_FWD-1:0]        fwd_is_load,
  input  logic [N_FWD*REG_AW-1:0] fwd_rd,
  input  logic [N_FWD*DATA_W-1:0] fwd_data,
  output logic [5:0]              stage_en,
  output logic [5:0]              stage_vld,
  output logic [DATA_W-1:0]       pc_out,
  output logic                    redirect,
  output logic [DATA_W-1:0]       op_a,
  output logic [DATA_W-1:0]       op_b,
  output logic [1:0]              state
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [31:0]             flush_cycles
`endif
);

  localparam logic [NUM_STAGES-1:0] STG_ALL = {NUM_STAGES{1'b1}};
  localparam logic [NUM_STAGES-1:0] M_F     = stg_bit(ST_F);
  localparam logic [NUM_STAGES-1:0] M_D     = stg_bit(ST_D);
  localparam logic [NUM_STAGES-1:0] M_RR    = stg_bit(ST_RR);
  localparam logic [NUM_STAGES-1:0] M_EX    = stg_bit(ST_EX);
  localparam logic [NUM_STAGES-1:0] M_MA    = stg_bit(ST_MA);
  localparam logic [3:0]            FLUSH_LOAD = 4'(FLUSH_CYC);

  hz_state_t          state_q;
  hz_state_t          nxt_state;
  logic [3:0]         cnt_q;
  logic [3:0]         nxt_cnt;
  logic [REG_AW-1:0]  ld_rd;
  logic               load_use;
  logic [N_FWD-1:0]   fwd_mask;
  logic [DATA_W-1:0]  fwd_a;
  logic [DATA_W-1:0]  fwd_b;
  logic               unused_is_load;

  // Only slot 0 (EX) can create a load-use hazard; older load flags are informational.
  assign unused_is_load = ^fwd_is_load;
  assign ld_rd          = fwd_rd[REG_AW-1:0];

  // Load in EX feeding a used RR source; skipped in LDSTALL since that load has already moved on.
  always_comb begin
    if (state_q == S_LDSTALL) begin
      load_use = 1'b0;
    end else begin
      load_use = fwd_vld[0] & fwd_is_load[0] &
                 ((rr_ra_use & (ld_rd == rr_ra)) | (rr_rb_use & (ld_rd == rr_rb)));
    end
  end

  // Slot 0 is the bubble left behind by the stall while in LDSTALL, so it must not forward.
  always_comb begin
    fwd_mask = fwd_vld;
    if (state_q == S_LDSTALL) begin
      fwd_mask[0] = 1'b0;
    end else begin
      fwd_mask[0] = fwd_vld[0];
    end
  end

  fwd_sel #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .N_FWD  (N_FWD)
  ) u_fwd_a (
    .src       (rr_ra),
    .src_use   (rr_ra_use),
    .rf_data   (rr_data_a),
    .slot_vld  (fwd_mask),
    .slot_rd   (fwd_rd),
    .slot_data (fwd_data),
    .data      (fwd_a)
  );

  fwd_sel #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .N_FWD  (N_FWD)
  ) u_fwd_b (
    .src       (rr_rb),
    .src_use   (rr_rb_use),
    .rf_data   (rr_data_b),
    .slot_vld  (fwd_mask),
    .slot_rd   (fwd_rd),
    .slot_data (fwd_data),
    .data      (fwd_b)
  );

  // Prioritised hazard resolution: pipeline controls and next FSM state for this cycle.
  always_comb begin
    stage_en  = '0;
    stage_vld = '0;
    pc_out    = '0;
    redirect  = 1'b0;
    nxt_state = S_RUN;
    nxt_cnt   = 4'd0;
    if (rst) begin
      nxt_state = S_RUN;
      nxt_cnt   = 4'd0;
    end else if (mispredict) begin
      stage_en  = STG_ALL;
      stage_vld = STG_ALL & ~(M_D | M_RR | M_EX);
      pc_out    = br_tgt;
      redirect  = 1'b1;
      nxt_state = S_FLUSH;
      nxt_cnt   = FLUSH_LOAD;
    end else if (mc_busy) begin
      stage_en  = STG_ALL & ~(M_F | M_D | M_RR | M_EX);
      stage_vld = STG_ALL & ~M_MA;
      pc_out    = pc_next;
      nxt_state = S_MCSTALL;
      nxt_cnt   = 4'd0;
    end else if (state_q == S_FLUSH) begin
      // RR only ever holds bubbles while flushing, so load-use and jumps are not acted on.
      stage_en  = STG_ALL;
      stage_vld = STG_ALL & ~M_D;
      pc_out    = pc_next;
      if (cnt_q <= 4'd1) begin
        nxt_state = S_RUN;
        nxt_cnt   = 4'd0;
      end else begin
        nxt_state = S_FLUSH;
        nxt_cnt   = cnt_q - 4'd1;
      end
    end else if (load_use) begin
      stage_en  = STG_ALL & ~(M_F | M_D | M_RR);
      stage_vld = STG_ALL & ~M_EX;
      pc_out    = pc_next;
      nxt_state = S_LDSTALL;
      nxt_cnt   = 4'd0;
    end else if (jmp_req) begin
      stage_en  = STG_ALL;
      stage_vld = STG_ALL & ~M_D;
      pc_out    = jmp_tgt;
      redirect  = 1'b1;
      nxt_state = S_RUN;
      nxt_cnt   = 4'd0;
    end else begin
      stage_en  = STG_ALL;
      stage_vld = STG_ALL;
      pc_out    = pc_next;
      nxt_state = S_RUN;
      nxt_cnt   = 4'd0;
    end
  end

  // Operand and state outputs, forced to zero / RUN while reset is held.
  always_comb begin
    if (rst) begin
      op_a  = '0;
      op_b  = '0;
      state = 2'(S_RUN);
    end else begin
      op_a  = fwd_a;
      op_b  = fwd_b;
      state = 2'(state_q);
    end
  end

  // Hazard FSM state and flush bubble counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= nxt_state;
      cnt_q   <= nxt_cnt;
    end
  end

`ifdef HAZ_STATS_EN
  // Saturating count of cycles spent in either stall state.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
    end else if (((state_q == S_LDSTALL) || (state_q == S_MCSTALL)) &&
                 (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end else begin
      stall_cycles <= stall_cycles;
    end
  end

  // Saturating count of cycles spent flushing after a mispredict.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cycles <= 32'd0;
    end else if ((state_q == S_FLUSH) && (flush_cycles != 32'hFFFF_FFFF)) begin
      flush_cycles <= flush_cycles + 32'd1;
    end else begin
      flush_cycles <= flush_cycles;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: each cycle's expected outputs
// are pushed to a scoreboard when the inputs are driven and popped and
// compared once the combinational outputs have settled.
module tb_pipe_hazard_ctrl;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int N_FWD  = 2;

  localparam logic [5:0]  ALL = 6'h3F;
  localparam logic [15:0] PCN = 16'h0100;
  localparam logic [15:0] RA  = 16'h1111;
  localparam logic [15:0] RB  = 16'h2222;

  logic                    clk;
  logic                    rst;
  logic [DATA_W-1:0]       pc_next;
  logic                    jmp_req;
  logic [DATA_W-1:0]       jmp_tgt;
  logic                    mispredict;
  logic [DATA_W-1:0]       br_tgt;
  logic                    mc_busy;
  logic [REG_AW-1:0]       rr_ra;
  logic [REG_AW-1:0]       rr_rb;
  logic                    rr_ra_use;
  logic                    rr_rb_use;
  logic [DATA_W-1:0]       rr_data_a;
  logic [DATA_W-1:0]       rr_data_b;
  logic [N_FWD-1:0]        fwd_vld;
  logic [N_FWD-1:0]        fwd_is_load;
  logic [N_FWD*REG_AW-1:0] fwd_rd;
  logic [N_FWD*DATA_W-1:0] fwd_data;
  logic [5:0]              stage_en;
  logic [5:0]              stage_vld;
  logic [DATA_W-1:0]       pc_out;
  logic                    redirect;
  logic [DATA_W-1:0]       op_a;
  logic [DATA_W-1:0]       op_b;
  logic [1:0]              state;
`ifdef HAZ_STATS_EN
  logic [31:0]             stall_cycles;
  logic [31:0]             flush_cycles;
`endif

  typedef struct packed {
    logic [5:0]  en;
    logic [5:0]  vld;
    logic [15:0] pc;
    logic        redir;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  st;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_no   = 0;

  pipe_hazard_ctrl #(
    .DATA_W    (DATA_W),
    .REG_AW    (REG_AW),
    .N_FWD     (N_FWD),
    .FLUSH_CYC (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_next     (pc_next),
    .jmp_req     (jmp_req),
    .jmp_tgt     (jmp_tgt),
    .mispredict  (mispredict),
    .br_tgt      (br_tgt),
    .mc_busy     (mc_busy),
    .rr_ra       (rr_ra),
    .rr_rb       (rr_rb),
    .rr_ra_use   (rr_ra_use),
    .rr_rb_use   (rr_rb_use),
    .rr_data_a   (rr_data_a),
    .rr_data_b   (rr_data_b),
    .fwd_vld     (fwd_vld),
    .fwd_is_load (fwd_is_load),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .stage_en    (stage_en),
    .stage_vld   (stage_vld),
    .pc_out      (pc_out),
    .redirect    (redirect),
    .op_a        (op_a),
    .op_b        (op_b),
    .state       (state)
`ifdef HAZ_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles)
`endif
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    pc_next     = PCN;
    jmp_req     = 1'b0;
    jmp_tgt     = 16'h0000;
    mispredict  = 1'b0;
    br_tgt      = 16'h0000;
    mc_busy     = 1'b0;
    rr_ra       = 3'd1;
    rr_rb       = 3'd4;
    rr_ra_use   = 1'b1;
    rr_rb_use   = 1'b1;
    rr_data_a   = RA;
    rr_data_b   = RB;
    fwd_vld     = 2'b00;
    fwd_is_load = 2'b00;
    fwd_rd      = '0;
    fwd_data    = '0;
  endtask

  // Push this cycle's expectation, let outputs settle, pop and compare, move to next negedge.
  task automatic cyc(input logic [5:0] en, input logic [5:0] vld, input logic [15:0] pc,
                     input logic redir, input logic [15:0] a, input logic [15:0] b,
                     input logic [1:0] st);
    exp_t e;
    e.en = en; e.vld = vld; e.pc = pc; e.redir = redir; e.a = a; e.b = b; e.st = st;
    sb.push_back(e);
    #2;
    check_val($sformatf("c%0d.sb_size", cyc_no), 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_val($sformatf("c%0d.stage_en", cyc_no),  32'(stage_en),  32'(e.en));
      check_val($sformatf("c%0d.stage_vld", cyc_no), 32'(stage_vld), 32'(e.vld));
      check_val($sformatf("c%0d.pc_out", cyc_no),    32'(pc_out),    32'(e.pc));
      check_val($sformatf("c%0d.redirect", cyc_no),  32'(redirect),  32'(e.redir));
      check_val($sformatf("c%0d.op_a", cyc_no),      32'(op_a),      32'(e.a));
      check_val($sformatf("c%0d.op_b", cyc_no),      32'(op_b),      32'(e.b));
      check_val($sformatf("c%0d.state", cyc_no),     32'(state),     32'(e.st));
    end else begin
      $display("FAIL c%0d.sb_pop: got empty expected entry", cyc_no);
    end
    cyc_no++;
    @(negedge clk);
  endtask

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    idle();
    mispredict = 1'b1;
    br_tgt     = 16'h0040;
    @(negedge clk);

    // Reset dominates every event.
    cyc(6'h00, 6'h00, 16'h0000, 1'b0, 16'h0000, 16'h0000, 2'd0);
    mispredict = 1'b0;
    mc_busy    = 1'b1;
    cyc(6'h00, 6'h00, 16'h0000, 1'b0, 16'h0000, 16'h0000, 2'd0);

    rst = 1'b0;
    idle();
    cyc(ALL, ALL, PCN, 1'b0, RA, RB, 2'd0);

    // Forwarding priority: EX (slot 0) beats MA (slot 1).
    rr_ra    = 3'd3;
    fwd_vld  = 2'b01;
    fwd_rd   = {3'd3, 3'd3};
    fwd_data = {16'h0055, 16'h00AA};
    cyc(ALL, ALL, PCN, 1'b0, 16'h00AA, RB, 2'd0);
    fwd_vld  = 2'b11;
    cyc(ALL, ALL, PCN, 1'b0, 16'h00AA, RB, 2'd0);
    fwd_vld  = 2'b10;
    cyc(ALL, ALL, PCN, 1'b0, 16'h0055, RB, 2'd0);
    fwd_vld   = 2'b11;
    rr_ra_use = 1'b0;
    cyc(ALL, ALL, PCN, 1'b0, RA, RB, 2'd0);
    rr_ra_use = 1'b1;
    rr_rb     = 3'd3;
    fwd_rd    = {3'd3, 3'd6};
    cyc(ALL, ALL, PCN, 1'b0, 16'h0055, 16'h0055, 2'd0);

    // Load-use on rb: unused source does not stall, used source does.
    idle();
    fwd_vld     = 2'b01;
    fwd_is_load = 2'b01;
    fwd_rd      = {3'd0, 3'd2};
    fwd_data    = {16'h0000, 16'hDEAD};
    rr_ra       = 3'd5;
    rr_rb       = 3'd2;
    rr_rb_use   = 1'b0;
    cyc(ALL, ALL, PCN, 1'b0, RA, RB, 2'd0);
    rr_rb_use = 1'b1;
    cyc(6'b111000, 6'b110111, PCN, 1'b0, RA, 16'hDEAD, 2'd0);
    fwd_vld  = 2'b11;
    fwd_rd   = {3'd2, 3'd2};
    fwd_data = {16'h0BEE, 16'hDEAD};
    cyc(ALL, ALL, PCN, 1'b0, RA, 16'h0BEE, 2'd1);
    idle();
    cyc(ALL, ALL, PCN, 1'b0, RA, RB, 2'd0);

    // Load-use on ra.
    fwd_vld     = 2'b01;
    fwd_is_load = 2'b01;
    fwd_rd      = {3'd0, 3'd2};
    fwd_data    = {16'h0000, 16'hDEAD};
    rr_ra       = 3'd2;
    cyc(6'b111000, 6'b110111, PCN, 1'b0, 16'hDEAD, RB, 2'd0);
    idle();
    cyc(ALL, ALL, PCN, 1'b0, RA, RB, 2'd1);
    cyc(ALL, ALL, PCN, 1'b0, RA, RB, 2'd0);

    // Jump in RUN.
    jmp_req = 1'b1;
    jmp_tgt = 16'h0200;
    cyc(ALL, 6'b111101, 16'h0200, 1'b1, RA, RB, 2'd0);
    idle();
    cyc(ALL, ALL, PCN, 1'b0, RA, RB, 2'd0);

    // Mispredict beats a same-cycle jump; jump ignored during FLUSH.
    mispredict = 1'b1;
    br_tgt     = 16'h0040;
    jmp_req    = 1'b1;
    jmp_tgt    = 16'h0200;
    cyc(ALL, 6'b110001, 16'h0040, 1'b1, RA, RB, 2'd0);
    mispredict = 1'b0;
    cyc(ALL, 6'b111101, PCN, 1'b0, RA, RB, 2'd3);
    cyc(ALL, 6'b111101, PCN, 1'b0, RA, RB, 2'd3);
    idle();
    cyc(ALL, ALL, PCN, 1'b0, RA, RB, 2'd0);

    // Mispredict during FLUSH reloads the counter.
    mispredict = 1'b1;
    br_tgt     = 16'h0080;
    cyc(ALL, 6'b110001, 16'h0080, 1'b1, RA, RB, 2'd0);
    cyc(ALL, 6'b110001, 16'h0080, 1'b1, RA, RB, 2'd3);
    mispredict = 1'b0;
    cyc(ALL, 6'b111101, PCN, 1'b0, RA, RB, 2'd3);
    cyc(ALL, 6'b111101, PCN, 1'b0, RA, RB, 2'd3);
    cyc(ALL, ALL, PCN, 1'b0, RA, RB, 2'd0);

    // mc_busy held 3 cycles.
    mc_busy = 1'b1;
    cyc(6'b110000, 6'b101111, PCN, 1'b0, RA, RB, 2'd0);
    cyc(6'b110000, 6'b101111, PCN, 1'b0, RA, RB, 2'd2);
    cyc(6'b110000, 6'b101111, PCN, 1'b0, RA, RB, 2'd2);
    mc_busy = 1'b0;
    cyc(ALL, ALL, PCN, 1'b0, RA, RB, 2'd2);
    cyc(ALL, ALL, PCN, 1'b0, RA, RB, 2'd0);

    // mc_busy outranks a load-use hazard.
    mc_busy     = 1'b1;
    fwd_vld     = 2'b01;
    fwd_is_load = 2'b01;
    fwd_rd      = {3'd0, 3'd2};
    fwd_data    = {16'h0000, 16'hDEAD};
    rr_rb       = 3'd2;
    cyc(6'b110000, 6'b101111, PCN, 1'b0, RA, 16'hDEAD, 2'd0);
    idle();
    cyc(ALL, ALL, PCN, 1'b0, RA, RB, 2'd2);
    cyc(ALL, ALL, PCN, 1'b0, RA, RB, 2'd0);

`ifdef HAZ_STATS_EN
    // 2 LDSTALL + 4 MCSTALL cycles, 2 + 3 FLUSH cycles so far.
    check_val("stall_cycles_run", stall_cycles, 32'd6);
    check_val("flush_cycles_run", flush_cycles, 32'd5);
`endif

    // Reset pulsed mid-flush (mispredict also beats mc_busy).
    mispredict = 1'b1;
    mc_busy    = 1'b1;
    br_tgt     = 16'h0040;
    cyc(ALL, 6'b110001, 16'h0040, 1'b1, RA, RB, 2'd0);
    idle();
    cyc(ALL, 6'b111101, PCN, 1'b0, RA, RB, 2'd3);
    rst = 1'b1;
    cyc(6'h00, 6'h00, 16'h0000, 1'b0, 16'h0000, 16'h0000, 2'd0);
    rst = 1'b0;
    cyc(ALL, ALL, PCN, 1'b0, RA, RB, 2'd0);
`ifdef HAZ_STATS_EN
    check_val("stall_cycles_rst", stall_cycles, 32'd0);
    check_val("flush_cycles_rst", flush_cycles, 32'd0);
`endif
    cyc(ALL, ALL, PCN, 1'b0, RA, RB, 2'd0);

    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter DATA_W, 16, width of the datapath, PC and operands.
REQ-002 Parameter REG_AW, 3, width of the register address.
REQ-003 Parameter N_FWD, 2, number of forwarding source slots; slot 0 is EX, the youngest.
REQ-004 Parameter FLUSH_CYC, 2, number of bubble cycles after a mispredict, range 1..15.
REQ-005 Port clk, in, 1: clock. Port rst, in, 1: reset, synchronous, active-high.
REQ-006 Port pc_next, in, DATA_W: sequential PC from fetch.
REQ-007 Ports jmp_req, in, 1 and jmp_tgt, in, DATA_W: jump request and target from decode.
REQ-008 Ports mispredict, in, 1 and br_tgt, in, DATA_W: branch redirect from EX.
REQ-009 Port mc_busy, in, 1: multi-cycle EX unit busy.
REQ-010 Ports rr_ra and rr_rb, in, REG_AW, plus rr_ra_use and rr_rb_use, in, 1: source registers in RR and their use flags.
REQ-011 Ports rr_data_a and rr_data_b, in, DATA_W: register-file read data.
REQ-012 Ports fwd_vld, fwd_is_load, in, N_FWD; fwd_rd, in, N_FWD*REG_AW; fwd_data, in, N_FWD*DATA_W: per-slot producer info.
REQ-013 Ports stage_en and stage_vld, out, 6: per-stage enable and valid, bit order F, D, RR, EX, MA, WB.
REQ-014 Ports pc_out, out, DATA_W and redirect, out, 1: fetch PC and redirect flag.
REQ-015 Ports op_a and op_b, out, DATA_W: forwarded operands to EX.
REQ-016 Port state, out, 2: current FSM state.

Function
REQ-017 FSM states: RUN=0, LDSTALL=1, MCSTALL=2, FLUSH=3.
REQ-018 All outputs are combinational from the state and the inputs, with zero-cycle latency.
REQ-019 Event priority is mispredict > mc_busy > load-use > jump. Only the highest-priority event acts in a cycle.
REQ-020 RUN with no event: stage_en=6'h3F, stage_vld=6'h3F, pc_out=pc_next, redirect=0.
REQ-021 Mispredict, from any state:
- pc_out=br_tgt, redirect=1.
- stage_vld D, RR and EX forced to 0.
- Next state is FLUSH with the counter loaded to FLUSH_CYC.
- A mispredict during FLUSH reloads the counter.
REQ-022 FLUSH:
- stage_vld D forced to 0; all enables 1.
- Counter decrements each cycle; at 1 the next state is RUN.
- A jump during FLUSH is ignored.
REQ-023 mc_busy:
- State is MCSTALL while mc_busy=1.
- stage_en F, D, RR and EX are 0; stage_vld MA is 0.
- Returns to RUN on the cycle after mc_busy falls.
REQ-024 Load-use condition: fwd_vld[0] & fwd_is_load[0], and fwd_rd[0] matches a used RR source.
- In that case, stage_en F, D and RR are 0 and stage_vld EX is 0 for exactly one cycle.
- Next state is LDSTALL.
- LDSTALL returns to RUN, with no load-use check against slot 0 in that cycle.
REQ-025 Jump in RUN: pc_out=jmp_tgt, redirect=1, stage_vld D=0; state unchanged.
REQ-026 Forwarding, per operand:
- Source is the lowest-index slot i with fwd_vld[i]=1, fwd_rd[i]==source register, and the use flag set.
- Otherwise rr_data. No register is special-cased.
REQ-027 During LDSTALL, slot 0 is excluded from forwarding.

Reset
REQ-028 While rst=1:
- stage_en=0, stage_vld=0, pc_out=0, redirect=0, op_a=0, op_b=0.
- state=RUN, flush counter=0.
REQ-029 Reset asserted mid-stall or mid-flush abandons it; the first cycle after reset is RUN.

Configuration
REQ-030 With HAZ_STATS_EN defined:
- Adds outputs stall_cycles and flush_cycles, 32 bits each, reset to 0.
- Each increments once per cycle spent in LDSTALL/MCSTALL or in FLUSH respectively, and saturates at 32'hFFFFFFFF.
REQ-031 Without HAZ_STATS_EN: these ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-032 Package pipe_ctrl_pkg holds:
- Stage index constants ST_F..ST_WB=0..5 and NUM_STAGES=6.
- The FSM state enum.
REQ-033 Sub-module fwd_sel (priority forwarding mux for one operand) is instantiated twice.

Verification
REQ-034 EX slot rd=3 with data 16'h00AA, RR ra=3 used -> op_a=16'h00AA. If MA slot also has rd=3 with data 16'h0055, op_a stays 16'h00AA.
REQ-035 Load in slot 0 with rd=2, RR rb=2 used -> one cycle with stage_en=6'b111000 and EX valid 0. Next cycle LDSTALL with op_b taken from slot 1, then RUN.
REQ-036 mispredict with br_tgt=16'h0040, FLUSH_CYC=2:
- Cycle 0: redirect=1, pc_out=16'h0040, stage_vld=6'b110001.
- Cycles 1-2: D invalid.
- Cycle 3: RUN.
REQ-037 jmp_req and mispredict in the same cycle -> pc_out=br_tgt. mc_busy held 3 cycles -> 3 cycles in MCSTALL, then RUN.
REQ-038 rst pulsed during FLUSH -> all outputs 0 during reset, state=RUN after it; with HAZ_STATS_EN, counters read 0.
